// File: rtl/matrix_tile_loader.sv
// Row-major element stream -> NUM_MG x NUM_PE tile register array with a level valid / ack handshake.
// Build option: define MATRIX_TILE_LOADER_PINGPONG_EN for a double-buffered tile store.
module matrix_tile_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 16,
  parameter int NUM_PE     = NUM_MG
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic [DATA_WIDTH-1:0]                 tile_elements [0:NUM_MG-1][0:NUM_PE-1],
  output logic                                  tile_val,
  input  logic                                  tile_ack,
  output logic [$clog2(NUM_MG*NUM_PE+1)-1:0]    fill_level
);

  localparam int TILE_SIZE = NUM_MG * NUM_PE;
  localparam int LVL_W     = $clog2(TILE_SIZE + 1);
  localparam int ROW_W     = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
  localparam int COL_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [LVL_W-1:0]  r_fill;

  logic              w_accept;
  logic              w_xfer;
  logic              w_wr;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_complete;
  logic [NUM_MG-1:0] w_row_hit;
  logic [NUM_PE-1:0] w_col_hit;

  // w_accept is the state-only acceptance term; handshake logic keys off it, not the in_ready port.
  assign w_xfer     = in_valid && w_accept;
  assign w_wr       = w_xfer && !clear;
  assign w_last_col = (r_col == COL_W'(NUM_PE - 1));
  assign w_last_row = (r_row == ROW_W'(NUM_MG - 1));
  assign w_complete = w_wr && w_last_row && w_last_col;
  assign fill_level = r_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_row  <= '0;
      r_col  <= '0;
      r_fill <= '0;
    end else if (w_xfer) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      r_fill <= w_complete ? '0 : r_fill + LVL_W'(1);
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_MG; gi++) begin : g_row_hit
      assign w_row_hit[gi] = (r_row == ROW_W'(gi));
    end
    for (gj = 0; gj < NUM_PE; gj++) begin : g_col_hit
      assign w_col_hit[gj] = (r_col == COL_W'(gj));
    end
  endgenerate

`ifdef MATRIX_TILE_LOADER_PINGPONG_EN

  logic [1:0] r_full;
  logic       r_wbuf;
  logic       r_rbuf;
  logic       w_ack;

  assign w_accept = !r_full[r_wbuf];
  assign in_ready = w_accept;
  assign tile_val = r_full[r_rbuf];
  assign w_ack    = tile_ack && r_full[r_rbuf];

  // Completion targets an empty buffer and ack a full one, so the two never hit the same flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
      r_wbuf <= 1'b0;
      r_rbuf <= 1'b0;
    end else begin
      if (w_complete) begin
        r_full[r_wbuf] <= 1'b1;
        r_wbuf         <= ~r_wbuf;
      end
      if (w_ack) begin
        r_full[r_rbuf] <= 1'b0;
        r_rbuf         <= ~r_rbuf;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_MG; gi++) begin : g_mg
      for (gj = 0; gj < NUM_PE; gj++) begin : g_pe
        logic [DATA_WIDTH-1:0] r_elem0;
        logic [DATA_WIDTH-1:0] r_elem1;
        logic                  w_hit;

        assign w_hit = w_wr && w_row_hit[gi] && w_col_hit[gj];

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_elem0 <= '0;
          end else if (w_hit && !r_wbuf) begin
            r_elem0 <= in_data;
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_elem1 <= '0;
          end else if (w_hit && r_wbuf) begin
            r_elem1 <= in_data;
          end
        end

        assign tile_elements[gi][gj] = r_rbuf ? r_elem1 : r_elem0;
      end
    end
  endgenerate

`else

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  assign w_accept = (r_state == ST_FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    tile_val     = 1'b0;
    case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (w_complete) begin
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        tile_val = 1'b1;
        if (tile_ack) begin
          w_state_next = ST_FILL;
        end
      end
    endcase
  end

  // The fill buffer doubles as the presented tile; it is frozen in PRESENT because nothing is accepted.
  generate
    for (gi = 0; gi < NUM_MG; gi++) begin : g_mg
      for (gj = 0; gj < NUM_PE; gj++) begin : g_pe
        logic [DATA_WIDTH-1:0] r_elem;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_elem <= '0;
          end else if (w_wr && w_row_hit[gi] && w_col_hit[gj]) begin
            r_elem <= in_data;
          end
        end

        assign tile_elements[gi][gj] = r_elem;
      end
    end
  endgenerate

`endif

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Directed self-checking bench for matrix_tile_loader (4x4 tile, 16-bit elements).
`timescale 1ns/1ps
module tb_matrix_tile_loader;
  localparam int DW = 16;
  localparam int MG = 4;
  localparam int PE = 4;
  localparam int LW = $clog2(MG*PE+1);
`ifdef MATRIX_TILE_LOADER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          tile_ack = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tile_val;
  logic [DW-1:0] tile_elements [0:MG-1][0:PE-1];
  logic [LW-1:0] fill_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_tile_loader #(
    .DATA_WIDTH(DW),
    .NUM_MG(MG),
    .NUM_PE(PE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .tile_elements(tile_elements),
    .tile_val(tile_val),
    .tile_ack(tile_ack),
    .fill_level(fill_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected tile: element [r][c] = base + PE*r + c (base 0 with zero stride used for the reset tile).
  task automatic check_tile(input string tag, input int base, input int stride);
    for (int r = 0; r < MG; r++) begin
      for (int c = 0; c < PE; c++) begin
        check($sformatf("%s[%0d][%0d]", tag, r, c), 32'(tile_elements[r][c]),
              32'((base + stride * (PE*r + c)) & 16'hFFFF));
      end
    end
    $display("tile %s: compared %0d elements", tag, MG*PE);
  endtask

  task automatic push(input int v, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(v);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    tile_ack = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int elem;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tile_val", 32'(tile_val), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 5; i++) push(50 + i, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("midfill_fill", 32'(fill_level), 32'd5);
    rst = 1'b0;
    #1;
    check("async_rst_fill", 32'(fill_level), 32'd0);
    check("async_rst_tile_val", 32'(tile_val), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check_tile("async_rst_tile", 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Row-major fill 0..15, then hold without ack
    for (int i = 0; i < 16; i++) push(i, 0);
    @(negedge clk);
    in_valid = !PP;
    in_data  = 16'hDEAD;
    check("rm_tile_val", 32'(tile_val), 32'd1);
    check("rm_in_ready", 32'(in_ready), 32'(PP));
    check("rm_fill", 32'(fill_level), 32'd0);
    check_tile("rm", 0, 1);
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("hold_tile_val", 32'(tile_val), 32'd1);
    check_tile("hold", 0, 1);
    ack_pulse();
    check("rm_ack_tile_val", 32'(tile_val), 32'd0);
    check("rm_ack_in_ready", 32'(in_ready), 32'd1);

    // Bubbled fill 100..115 with fill_level tracking
    for (int i = 0; i < 16; i++) begin
      push(100 + i, i % 3);
      check($sformatf("bub_fill_%0d", i), 32'(fill_level), 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bub_tile_val", 32'(tile_val), 32'd1);
    check("bub_fill_done", 32'(fill_level), 32'd0);
    check_tile("bub", 100, 1);
    ack_pulse();
    check("bub_ack_tile_val", 32'(tile_val), 32'd0);
    ack_pulse();
    check("spur_ack_tile_val", 32'(tile_val), 32'd0);
    check("spur_ack_in_ready", 32'(in_ready), 32'd1);
    check("spur_ack_fill", 32'(fill_level), 32'd0);

    // Clear coinciding with the 8th element
    for (int i = 0; i < 7; i++) push(200 + i, 0);
    @(negedge clk);
    in_data = DW'(207);
    clear   = 1'b1;
    check("pre_clear_fill", 32'(fill_level), 32'd7);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_fill", 32'(fill_level), 32'd0);
    check("clear_tile_val", 32'(tile_val), 32'd0);
    for (int i = 0; i < 16; i++) push(16'hAA00 + i, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("aa_tile_val", 32'(tile_val), 32'd1);
    check_tile("aa", 16'hAA00, 1);
    ack_pulse();

    // Clear coinciding with the completing element discards the tile
    for (int i = 0; i < 15; i++) push(300 + i, 0);
    @(negedge clk);
    in_data = DW'(315);
    clear   = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_last_tile_val", 32'(tile_val), 32'd0);
    check("clr_last_fill", 32'(fill_level), 32'd0);
    check("clr_last_in_ready", 32'(in_ready), 32'd1);

`ifdef MATRIX_TILE_LOADER_PINGPONG_EN
    // Continuous 48-element stream, first ack 20 cycles after first presentation
    do_reset();
    for (int t = 0; t < 56; t++) begin
      @(negedge clk);
      if (t == 20) check("pp_ready_mid", 32'(in_ready), 32'd1);
      if (t == 32) begin
        check("pp_t32_in_ready", 32'(in_ready), 32'd0);
        check("pp_t32_tile_val", 32'(tile_val), 32'd1);
        check_tile("pp_tile0", 1000, 1);
      end
      if (t == 35) check("pp_t35_in_ready", 32'(in_ready), 32'd0);
      if (t == 36) begin
        check("pp_t36_in_ready", 32'(in_ready), 32'd1);
        check("pp_t36_tile_val", 32'(tile_val), 32'd1);
        check_tile("pp_tile1", 1016, 1);
      end
      if (t == 52) begin
        check("pp_t52_in_ready", 32'(in_ready), 32'd0);
        check("pp_t52_tile_val", 32'(tile_val), 32'd1);
      end
      if (t == 53) begin
        check("pp_t53_tile_val", 32'(tile_val), 32'd1);
        check("pp_t53_in_ready", 32'(in_ready), 32'd1);
        check_tile("pp_tile2", 1032, 1);
      end
      if (t == 54) check("pp_t54_tile_val", 32'(tile_val), 32'd0);
      tile_ack = (t == 35) || (t == 52) || (t == 53);
      elem     = (t < 32) ? t : ((t <= 36) ? 32 : t - 4);
      in_valid = (elem < 48);
      in_data  = DW'(1000 + elem);
    end
    in_valid = 1'b0;
    tile_ack = 1'b0;

    // Completion of buffer 1 on the same edge as the ack of buffer 0
    do_reset();
    for (int i = 0; i < 31; i++) push(2000 + i, 0);
    @(negedge clk);
    in_data  = DW'(2031);
    tile_ack = 1'b1;
    check_tile("sim_before", 2000, 1);
    @(negedge clk);
    tile_ack = 1'b0;
    in_valid = 1'b0;
    check("sim_tile_val", 32'(tile_val), 32'd1);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    check("sim_fill", 32'(fill_level), 32'd0);
    check_tile("sim_after", 2016, 1);
    ack_pulse();
    check("sim_final_tile_val", 32'(tile_val), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_tile_loader.md
# matrix_tile_loader

- Upstream feeder for the matrix transpose top.
- Accepts a valid/ready stream of DATA_WIDTH elements in row-major order and assembles them into a NUM_MG x NUM_PE tile register array.
- Presents the completed tile on `tile_elements` with a level `tile_val` held until the transpose stage acknowledges it; the tile drives the transpose block's `input_elements`/`in_val` directly.

## Interface
- `DATA_WIDTH`, 64, element width in bits
- `NUM_MG`, 16, tile rows (one per MG)
- `NUM_PE`, NUM_MG, tile columns (one per PE)
- `clk`  input  1  sole clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset (asserted when 0)
- `clear`  input  1  synchronous discard of the partially filled tile
- `in_valid`  input  1  `in_data` valid
- `in_ready`  output  1  loader can accept an element this cycle
- `in_data`  input  DATA_WIDTH  stream element
- `tile_elements`  output  [DATA_WIDTH-1:0] [0:NUM_MG-1][0:NUM_PE-1]  presented tile
- `tile_val`  output  1  `tile_elements` holds a complete tile
- `tile_ack`  input  1  consumer takes the presented tile
- `fill_level`  output  $clog2(NUM_MG*NUM_PE+1)  elements held in the fill buffer

## Operation
- **Transfer.** An element transfers on a rising edge where `in_valid && in_ready`. It is written to `[row][col]` of the fill buffer.
- **Index advance.** `col` increments and wraps NUM_PE-1 -> 0; on wrap, `row` increments. After element NUM_MG*NUM_PE-1, `row` and `col` return to 0.
- **State machine (single buffer).**
  - FILL: `in_ready`=1, `tile_val`=0. The last element transfers -> PRESENT.
  - PRESENT: `in_ready`=0, `tile_val`=1, tile frozen. `tile_ack`=1 -> FILL.
- **`tile_ack`** is ignored while `tile_val`=0.
- **`in_ready`** is a combinational function of state only, never of `in_valid`.
- **`fill_level`** counts elements written in the current fill: 0..NUM_MG*NUM_PE-1. It returns to 0 on tile completion.
- **`clear`** zeroes `row`, `col` and `fill_level`. Buffer contents are not zeroed. It does not affect a tile already in PRESENT.
  - If `clear` coincides with a transfer, `clear` wins and the element is dropped.
  - If `clear` coincides with the completing element, the tile is discarded and no PRESENT occurs.
- **Reset.** All state clears: FILL, indices 0, `tile_elements` all 0, `tile_val`=0, `in_ready`=1 (asserted combinationally from FILL while reset is held), `fill_level`=0.
- **Reset mid-fill or mid-present** discards everything immediately (asynchronous).

## Timing
- Last element transfers at edge N -> `tile_val`=1 and the tile is stable from edge N; `in_ready`=0 from edge N.
- `tile_ack` sampled high at edge M with `tile_val`=1 -> `tile_val`=0 and `in_ready`=1 from edge M. The earliest next transfer is edge M+1.
- The minimum tile period (single buffer) is NUM_MG*NUM_PE transfer cycles plus 1 acknowledge cycle.
- `tile_elements` changes only on transfer edges into the fill buffer. No combinational path from `in_data` to `tile_elements`.

## Configuration
- **`MATRIX_TILE_LOADER_PINGPONG_EN` defined:** two tile buffers, each with a full flag; write pointer `wbuf` and read pointer `rbuf`, both reset to 0.
  - Filling proceeds into `wbuf`. Completion sets `full[wbuf]` and toggles `wbuf`.
  - `in_ready` = !`full[wbuf]`.
  - `tile_elements` = buffer `rbuf`; `tile_val` = `full[rbuf]`.
  - Ack clears `full[rbuf]` and toggles `rbuf`.
  - Completion and ack in the same edge on different buffers are both applied.
  - Back-to-back tiles stream with no gap on the input when acks keep pace.
- **Not defined:** single buffer with the FILL/PRESENT machine above. No second buffer is instantiated.

## Test plan
(NUM_MG=NUM_PE=4 unless noted.)
- **Reset values:** assert `rst`=0 mid-fill after 5 elements -> `tile_val`=0, `fill_level`=0, `tile_elements` all 0, `in_ready`=1. A fresh 16-element fill then completes normally.
- **Row-major fill:** stream values 0..15 with `in_valid` held -> after the 16th transfer edge, `tile_val`=1 and `tile_elements[r][c]`=4r+c. `in_ready`=0 (single buffer). Hold `tile_ack`=0 for 10 cycles -> tile unchanged.
- **Handshake with bubbles:** random `in_valid` gaps with values 100..115 -> same placement, `fill_level` tracks 0..15. Pulse `tile_ack` -> `tile_val`=0 next edge; a spurious `tile_ack` while `tile_val`=0 has no effect.
- **Clear:** after 7 elements assert `clear` together with an 8th valid element -> element dropped, `fill_level`=0. A 16-element stream of 0xAA.. values then fills `[0][0]`..`[3][3]`.
- **Ping-pong (macro defined):** stream 48 elements continuously with `tile_ack` delayed 20 cycles.
  - `in_ready` drops after element 32 and recovers the edge after the first ack.
  - The second tile is presented the edge after the first ack; the tile order is preserved.
- **Simultaneous complete/ack (macro defined):** the last element of buffer 1 and the ack of buffer 0 on the same edge -> `tile_val` stays 1 and shows buffer 1; `full` flags are {0,1}.
